spi_reg_loader: RTL

- Upstream stage feeding the raybox-zero renderer's general register port.
- Receives register-write frames over an asynchronous SPI slave interface and synchronises the pins into the clk domain.
- Validates frame length and holds one pending write.
- Commits the pending write as a single-cycle strobe at the start of vertical blanking, so registers never change mid-frame.

---
 rtl/spi_reg_loader_if.sv | 23 ++
 rtl/spi_reg_loader.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/spi_reg_loader_if.sv
// SPI pin bundle plus the register-write port that spi_reg_loader drives.
// The slave modport is the loader's view; master is the driver/consumer side.
interface spi_reg_loader_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 24
);
  logic              i_sclk;
  logic              i_mosi;
  logic              i_ss_n;
  logic              o_wr;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;

  modport slave (
    input  i_sclk, i_mosi, i_ss_n,
    output o_wr, o_wr_addr, o_wr_data
  );

  modport master (
    output i_sclk, i_mosi, i_ss_n,
    input  o_wr, o_wr_addr, o_wr_data
  );
endinterface

// File: rtl/spi_reg_loader.sv
// SPI register-write receiver: synchronises the SPI pins, checks frame length,
// holds one pending write and commits it as a one-cycle strobe on vblank rise.
module spi_reg_loader #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_reg_loader_if.slave       bus,
  input  logic                  i_vblank,
  output logic                  o_pending,
  output logic                  o_err,
  output logic                  o_overrun
);

  localparam int unsigned FRAME_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
  localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]   CNT_SAT    = CNT_W'(FRAME_W + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES);

  typedef enum logic {IDLE, SHIFT} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
  logic                   sclk_prev_q, mosi_prev_q, ss_prev_q, vb_prev_q;
  logic [FLUSH_W-1:0]     flush_q, flush_d;
  logic                   armed_q, armed_d;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_W-1:0]     shift_q, shift_d;
  logic                   pend_q, pend_d;
  logic [ADDR_W-1:0]      pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0]      pend_data_q, pend_data_d;
  logic                   wr_q, wr_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]      wr_data_q, wr_data_d;
  logic                   err_q, err_d;
  logic                   ovr_q, ovr_d;

  logic sclk_s, ss_s, sclk_rise, ss_rise, ss_fall, vb_rise, commit, frame_ok;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;
  // A select held low across reset would look like a fresh falling edge once
  // the idle reset values flush out; only arm after a genuine high is seen.
  assign ss_fall   = armed_q & ~ss_s & ss_prev_q;
  assign vb_rise   = i_vblank & ~vb_prev_q;
  assign commit    = vb_rise & pend_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      mosi_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      vb_prev_q   <= 1'b0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.i_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.i_mosi};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.i_ss_n};
      sclk_prev_q <= sclk_s;
      mosi_prev_q <= mosi_sync_q[SYNC_STAGES-1];
      ss_prev_q   <= ss_s;
      vb_prev_q   <= i_vblank;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      wr_q        <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      wr_q        <= wr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
    end
  end

  always_comb begin
    flush_d     = (flush_q == FLUSH_DONE) ? flush_q : flush_q + FLUSH_W'(1);
    armed_d     = armed_q | ((flush_q == FLUSH_DONE) & ss_s);
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    wr_d        = 1'b0;
    wr_addr_d   = '0;
    wr_data_d   = '0;
    err_d       = 1'b0;
    ovr_d       = 1'b0;
    frame_ok    = 1'b0;

    if (commit) begin
      wr_d      = 1'b1;
      wr_addr_d = pend_addr_q;
      wr_data_d = pend_data_q;
      pend_d    = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (cnt_q == CNT_FULL) frame_ok = 1'b1;
          else                   err_d    = 1'b1;
        end else if (sclk_rise) begin
          // mosi is taken from its history flop: one cycle older than the
          // sclk edge, well inside the data-stable half period.
          shift_d = {shift_q[FRAME_W-2:0], mosi_prev_q};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_ok) begin
      pend_d      = 1'b1;
      pend_addr_d = shift_q[FRAME_W-1:DATA_W];
      pend_data_d = shift_q[DATA_W-1:0];
      ovr_d       = pend_q & ~commit;
    end
  end

  assign bus.o_wr      = wr_q;
  assign bus.o_wr_addr = wr_addr_q;
  assign bus.o_wr_data = wr_data_q;
  assign o_pending     = pend_q;
  assign o_err         = err_q;
  assign o_overrun     = ovr_q;

endmodule
